serial_comp: RTL
================

SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL provide parameter SLICE, default 4: bits compared per clock; WIDTH SHALL be an integer multiple of SLICE; NSLICE = WIDTH/SLICE.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request to begin a comparison; accepted only when ready=1.
REQ-007 a  in  WIDTH  operand A, sampled on the accepting edge.
REQ-008 b  in  WIDTH  operand B, sampled on the accepting edge.
REQ-009 is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled on the accepting edge.
REQ-010 great, equal, less  in  1 each  cascade inputs from a lower-significance stage; sampled on the accepting edge.
REQ-011 ready  out  1  high in IDLE only.
REQ-012 done  out  1  one-cycle pulse marking a new valid result.
REQ-013 L, EQ, G  out  1 each  registered result: A<B, A==B, A>B.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 SHALL capture a, b, is_signed, great, equal, less into internal registers, load slice index idx=NSLICE-1, and go to RUN.
REQ-016 start with ready=0 SHALL be ignored, with no effect on captured data or the FSM.
REQ-017 RUN: each cycle SHALL compare captured slice idx of A vs B as unsigned SLICE-bit values, MSB slice first.
REQ-018 Signed mode: for slice NSLICE-1 only, the MSB of both operands SHALL be inverted before comparison.
REQ-019 Unequal slice SHALL register G=1 (A slice > B slice) or L=1 (A slice < B slice), other two outputs 0, and go to DONE (early exit).
REQ-020 Equal slice with idx>0 SHALL decrement idx and stay in RUN.
REQ-021 Equal slice with idx=0 SHALL resolve from captured cascade with priority great > less > equal: G=1, else L=1, else EQ=1; all cascade inputs 0 SHALL give EQ=1.
REQ-022 After any resolution exactly one of L/EQ/G SHALL be 1.
REQ-023 DONE: done=1 and ready=0 for exactly one cycle, then go to IDLE.
REQ-024 Latency: start accepted at edge T, k slices examined (1<=k<=NSLICE) -> result registered and done high from edge T+k to edge T+k+1; ready high again from edge T+k+1.
REQ-025 L/EQ/G SHALL hold their value from one resolution until the next resolution or reset.
REQ-026 Changes on a, b, is_signed or cascade inputs after the accepting edge SHALL not affect the in-progress comparison.

Reset
REQ-027 rst=1 SHALL immediately, independent of clk, force state IDLE, idx=0, ready=1, done=0, L=0, EQ=0, G=0.
REQ-028 rst asserted in RUN or DONE SHALL abort the comparison; no done pulse SHALL follow for it.
REQ-029 First start SHALL be accepted on the first rising edge with rst=0.

Verification (WIDTH=16, SLICE=4)
REQ-030 unsigned a=0x8000, b=0x7FFF, start -> done 1 cycle after accept, G=1, L=0, EQ=0.
REQ-031 a=b=0x1234, less=1, great=0 -> done 4 cycles after accept, L=1; repeat with all cascade inputs 0 -> EQ=1.
REQ-032 a=0xFFFF, b=0x0001: is_signed=1 -> L=1 after 1 cycle; is_signed=0 -> G=1 after 1 cycle.
REQ-033 a=0x1235, b=0x1234, second start pulsed and operands changed during RUN -> single done after 4 cycles, G=1; second start ignored.
REQ-034 rst pulsed during RUN (idx=2) -> ready=1, done=0, L=EQ=G=0 immediately; no later done until a new start.
REQ-035 signed a=0x8000 (-32768), b=0x8000, great=1 -> done after 4 cycles, G=1.

Source files
------------

// File: rtl/serial_comp.sv
// Multi-cycle magnitude comparator: walks SLICE-bit slices MSB first, exits early
// on the first unequal slice, and falls back to a cascade input when all slices match.
module serial_comp #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             great,
  input  logic             equal,
  input  logic             less,
  output logic             ready,
  output logic             done,
  output logic             L,
  output logic             EQ,
  output logic             G
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [IDXW-1:0]  idx, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q, g_q, e_q, l_q;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SLICE-1:0] a_sl, b_sl;
  logic             load, res_we, res_l, res_eq, res_g;

  // Current slice of the captured operands. In signed mode the sign bits are
  // flipped on the top slice so an unsigned compare orders two's-complement values.
  always_comb begin
    a_sh = a_q >> (SLICE * int'(idx));
    b_sh = b_q >> (SLICE * int'(idx));
    a_sl = a_sh[SLICE-1:0];
    b_sl = b_sh[SLICE-1:0];
    if (sgn_q && (idx == TOP_IDX)) begin
      a_sl[SLICE-1] = ~a_sl[SLICE-1];
      b_sl[SLICE-1] = ~b_sl[SLICE-1];
    end
  end

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    load    = 1'b0;
    res_we  = 1'b0;
    res_l   = 1'b0;
    res_eq  = 1'b0;
    res_g   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = TOP_IDX;
          state_d = RUN;
        end
      end
      RUN: begin
        if (a_sl > b_sl) begin
          res_we  = 1'b1;
          res_g   = 1'b1;
          state_d = DONE;
        end else if (a_sl < b_sl) begin
          res_we  = 1'b1;
          res_l   = 1'b1;
          state_d = DONE;
        end else if (idx != '0) begin
          idx_d = idx - 1'b1;
        end else begin
          res_we  = 1'b1;
          state_d = DONE;
          if (g_q)      res_g  = 1'b1;
          else if (l_q) res_l  = 1'b1;
          // An all-zero cascade also resolves as equal.
          else          res_eq = e_q | ~(g_q | l_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // NOTE: the operand capture registers are reset too; they are few and a
  // known post-reset value keeps simulation free of X on the slice compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      g_q   <= 1'b0;
      e_q   <= 1'b0;
      l_q   <= 1'b0;
      L     <= 1'b0;
      EQ    <= 1'b0;
      G     <= 1'b0;
    end else begin
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        sgn_q <= is_signed;
        g_q   <= great;
        e_q   <= equal;
        l_q   <= less;
      end
      if (res_we) begin
        L  <= res_l;
        EQ <= res_eq;
        G  <= res_g;
      end
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule
